// File: rtl/data_wr_sm.sv
// data_wr_sm: write-side controller for the 16-bit asynchronous FIFO.
// Accepts producer words over valid/ready into a two-entry skid buffer
// (head = oldest, tail = newest) and drains it into the FIFO write port
// whenever the FIFO is not full. Also keeps debug counters of words
// written (wrapping) and cycles stalled on full (saturating).
module data_wr_sm #(
    parameter int DW = 16,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] data_in,
    input  logic          data_valid,
    output logic          data_ready,
    input  logic          Wfull,
    output logic          Winc,
    output logic [DW-1:0] Wdata,
    output logic [CW-1:0] wr_count,
    output logic [CW-1:0] stall_count
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    state_t        state_reg;
    logic [DW-1:0] head_reg;
    logic [DW-1:0] tail_reg;
    logic [CW-1:0] wr_count_reg;
    logic [CW-1:0] stall_count_reg;

    logic push;
    logic pop;

    // Ready depends only on occupancy, never on data_valid, so the
    // producer sees no combinational loop through this block.
    assign data_ready = rst_n & (state_reg != S_TWO);
    // Wfull gates the write in the same cycle; nothing is written while full.
    assign Winc       = rst_n & (state_reg != S_EMPTY) & ~Wfull;
    assign Wdata      = head_reg;
    assign push       = data_valid & data_ready;
    assign pop        = Winc;

    assign wr_count    = wr_count_reg;
    assign stall_count = stall_count_reg;

    // Occupancy state machine and skid buffer registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= S_EMPTY;
            head_reg  <= '0;
            tail_reg  <= '0;
        end else begin
            case (state_reg)
                S_EMPTY: begin
                    if (push) begin
                        state_reg <= S_ONE;
                        head_reg  <= data_in;
                    end
                end
                S_ONE: begin
                    if (push && !pop) begin
                        state_reg <= S_TWO;
                        tail_reg  <= data_in;
                    end else if (!push && pop) begin
                        state_reg <= S_EMPTY;
                    end else if (push && pop) begin
                        // Head is leaving this edge; the new word replaces it.
                        head_reg  <= data_in;
                    end
                end
                S_TWO: begin
                    // data_ready is low here, so only a pop can occur.
                    if (pop) begin
                        state_reg <= S_ONE;
                        head_reg  <= tail_reg;
                    end
                end
                default: begin
                    state_reg <= S_EMPTY;
                end
            endcase
        end
    end

    // Debug counters: wrapping write count, saturating full-stall count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_count_reg    <= '0;
            stall_count_reg <= '0;
        end else begin
            if (pop) begin
                wr_count_reg <= wr_count_reg + 1'b1;
            end
            if ((state_reg != S_EMPTY) && Wfull && (stall_count_reg != {CW{1'b1}})) begin
                stall_count_reg <= stall_count_reg + 1'b1;
            end
        end
    end

endmodule
